phase_sequencer: RTL and testbench

Parametrised instruction-phase sequencer for the stack CPU control path. It generates the one-hot phase strobes (`phase_fetch`, `phase_decode`, `phase_exec`, `phase_rdmem`) that the control-signal logic gates decoder outputs with. It generalises the fixed four-phase cycle with:

- configurable memory wait states;
- optional skipping of the read-memory phase for instructions that do not read memory;
- a pipeline stall input;
- a retired-instruction counter.

---
 rtl/phase_sequencer.sv | 121 ++++++++++++
 tb/tb_phase_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer for the stack CPU control path: one-hot phase strobes
// with optional memory wait states, RDMEM skipping, stall freeze and a retired counter.
module phase_sequencer #(
   parameter int MEM_WAIT   = 0,
   parameter bit SKIP_RDMEM = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 insn_rd,
   input  logic                 insn_wr,
   output logic                 phase_fetch,
   output logic                 phase_decode,
   output logic                 phase_exec,
   output logic                 phase_rdmem,
   output logic                 phase_half,
   output logic                 mem_wait,
   output logic                 insn_end,
   output logic [CNT_WIDTH-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_FWAIT  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MWAIT  = 3'd4,
      S_RDMEM  = 3'd5
   } state_t;

   localparam logic       HAS_WAIT  = (MEM_WAIT > 0);
   localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

   state_t                state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic                  rd_q, rd_d;
   logic [CNT_WIDTH-1:0]  retired_q, retired_d;
   logic                  acc, need_rd;

   // Next-state logic; a stalled cycle leaves every register at its current value.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      rd_d     = rd_q;
      insn_end = 1'b0;
      acc      = insn_rd | insn_wr;
      need_rd  = insn_rd | ~SKIP_RDMEM;
      if (!stall) begin
         unique case (state_q)
            S_FETCH: begin
               if (HAS_WAIT) begin
                  state_d = S_FWAIT;
                  wcnt_d  = WAIT_LOAD;
               end else begin
                  state_d = S_DECODE;
               end
            end
            S_FWAIT: begin
               if (wcnt_q == 4'd0) state_d = S_DECODE;
               else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
               // rd_q remembers whether RDMEM follows the post-access wait.
               rd_d = need_rd;
               if (acc && HAS_WAIT) begin
                  state_d = S_MWAIT;
                  wcnt_d  = WAIT_LOAD;
               end else if (need_rd) begin
                  state_d = S_RDMEM;
               end else begin
                  state_d  = S_FETCH;
                  insn_end = 1'b1;
               end
            end
            S_MWAIT: begin
               if (wcnt_q == 4'd0) begin
                  if (rd_q) begin
                     state_d = S_RDMEM;
                  end else begin
                     state_d  = S_FETCH;
                     insn_end = 1'b1;
                  end
               end else begin
                  wcnt_d = wcnt_q - 4'd1;
               end
            end
            S_RDMEM: begin
               state_d  = S_FETCH;
               insn_end = 1'b1;
            end
            default: state_d = S_FETCH;
         endcase
      end
      retired_d = insn_end ? retired_q + CNT_WIDTH'(1) : retired_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wcnt_q    <= 4'd0;
         rd_q      <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         rd_q      <= rd_d;
         retired_q <= retired_d;
      end
   end

   assign phase_fetch  = (state_q == S_FETCH)  & ~stall;
   assign phase_decode = (state_q == S_DECODE) & ~stall;
   assign phase_exec   = (state_q == S_EXEC)   & ~stall;
   assign phase_rdmem  = (state_q == S_RDMEM)  & ~stall;
   assign phase_half   = phase_decode | phase_exec;
   assign mem_wait     = ((state_q == S_FWAIT) | (state_q == S_MWAIT)) & ~stall;
   assign retired      = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench: five sequencer configurations run side by side, each checked every
// cycle against a position-within-instruction model built from the cycles-per-instruction rule.
module tb_phase_sequencer;

   localparam int N = 5;
   localparam int MW_T[N] = '{0, 0, 2, 3, 15};
   localparam bit SK_T[N] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam int CW_T[N] = '{16, 16, 16, 2, 8};

   localparam int L_F = 0, L_W = 1, L_D = 2, L_E = 3, L_R = 4;

   logic clk = 1'b0;
   logic rst, stall;
   logic rd_i[N], wr_i[N];
   logic f_o[N], d_o[N], e_o[N], r_o[N], h_o[N], w_o[N], end_o[N];
   logic [15:0] ret_o[N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [CW_T[g]-1:0] ret_w;
      phase_sequencer #(
         .MEM_WAIT  (MW_T[g]),
         .SKIP_RDMEM(SK_T[g]),
         .CNT_WIDTH (CW_T[g])
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .stall       (stall),
         .insn_rd     (rd_i[g]),
         .insn_wr     (wr_i[g]),
         .phase_fetch (f_o[g]),
         .phase_decode(d_o[g]),
         .phase_exec  (e_o[g]),
         .phase_rdmem (r_o[g]),
         .phase_half  (h_o[g]),
         .mem_wait    (w_o[g]),
         .insn_end    (end_o[g]),
         .retired     (ret_w)
      );
      assign ret_o[g] = 16'(ret_w);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: cycles into the current instruction, plus the access kind seen in EXEC.
   int m_pos[N];
   bit m_acc[N], m_need[N];
   int m_ret[N];

   function automatic int ins_len(int mw, bit acc, bit need);
      return 3 + mw + (acc ? mw : 0) + (need ? 1 : 0);
   endfunction

   function automatic int label_of(int mw, int pos, bit acc);
      if (pos == 0)                            return L_F;
      if (pos <= mw)                           return L_W;
      if (pos == mw + 1)                       return L_D;
      if (pos == mw + 2)                       return L_E;
      if (pos <= mw + 2 + (acc ? mw : 0))      return L_W;
      return L_R;
   endfunction

   task automatic check_unit(input int k);
      int  mw, lab, len;
      bit  acc, need;
      logic [6:0] exp_v, got_v;
      mw = MW_T[k];
      if (m_pos[k] == mw + 2) begin
         acc  = rd_i[k] | wr_i[k];
         need = rd_i[k] | !SK_T[k];
      end else begin
         acc  = m_acc[k];
         need = m_need[k];
      end
      lab = label_of(mw, m_pos[k], acc);
      len = ins_len(mw, acc, need);
      exp_v[6] = !stall && lab == L_F;
      exp_v[5] = !stall && lab == L_D;
      exp_v[4] = !stall && lab == L_E;
      exp_v[3] = !stall && lab == L_R;
      exp_v[2] = !stall && (lab == L_D || lab == L_E);
      exp_v[1] = !stall && lab == L_W;
      exp_v[0] = !stall && m_pos[k] == len - 1;
      got_v = {f_o[k], d_o[k], e_o[k], r_o[k], h_o[k], w_o[k], end_o[k]};
      chk($sformatf("strobes[%0d] f,d,e,r,half,wait,end", k), 32'(got_v), 32'(exp_v));
      chk($sformatf("retired[%0d]", k), 32'(ret_o[k]),
          32'(m_ret[k] & ((1 << CW_T[k]) - 1)));
   endtask

   task automatic advance_unit(input int k);
      int mw;
      mw = MW_T[k];
      if (rst) begin
         m_pos[k] = 0; m_acc[k] = 1'b0; m_need[k] = 1'b0; m_ret[k] = 0;
      end else if (!stall) begin
         if (m_pos[k] == mw + 2) begin
            m_acc[k]  = rd_i[k] | wr_i[k];
            m_need[k] = rd_i[k] | !SK_T[k];
         end
         if (m_pos[k] == ins_len(mw, m_acc[k], m_need[k]) - 1) begin
            m_pos[k] = 0;
            m_ret[k]++;
         end else begin
            m_pos[k]++;
         end
      end
   endtask

   initial begin
      bit known;
      known = 1'b0;
      rst   = 1'b1;
      stall = 1'b0;
      for (int k = 0; k < N; k++) begin
         rd_i[k] = 1'b0; wr_i[k] = 1'b0;
         m_pos[k] = 0; m_acc[k] = 1'b0; m_need[k] = 1'b0; m_ret[k] = 0;
      end
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (cyc < 2)         rst = 1'b1;
         else if (cyc < 40)   rst = 1'b0;
         else                 rst = ($urandom_range(0, 99) < 2);
         if (cyc < 2 || cyc < 60) stall = 1'b0;
         else                      stall = ($urandom_range(0, 99) < 20);
         for (int k = 0; k < N; k++) begin
            rd_i[k] = 1'($urandom_range(0, 1));
            wr_i[k] = 1'($urandom_range(0, 1));
         end
         #1;
         if (known) begin
            for (int k = 0; k < N; k++) check_unit(k);
         end
         @(posedge clk);
         if (rst) known = 1'b1;
         for (int k = 0; k < N; k++) advance_unit(k);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
